// File: rtl/rvsteel_bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rvsteel_bus_arbiter_defines (package)
// Description : Shared constants for the system-bus arbiter: bus widths,
//               arbiter state encoding and transaction type encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package rvsteel_bus_arbiter_defines;

    localparam int c_ADDR_WIDTH = 32;
    localparam int c_DATA_WIDTH = 32;
    localparam int c_STRB_WIDTH = 4;

    localparam logic [1:0] c_STATE_IDLE  = 2'd0;
    localparam logic [1:0] c_STATE_ISSUE = 2'd1;
    localparam logic [1:0] c_STATE_WAIT  = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE  = c_STATE_IDLE,
        S_ISSUE = c_STATE_ISSUE,
        S_WAIT  = c_STATE_WAIT
    } state_t;

    localparam logic c_TYPE_READ  = 1'b0;
    localparam logic c_TYPE_WRITE = 1'b1;

endpackage
`default_nettype wire

// File: rtl/rvsteel_rr_picker.sv
`default_nettype none
// ============================================================================
// Module      : rvsteel_rr_picker
// Description : Combinational round-robin picker. Selects the first set
//               request at index >= i_ptr, wrapping modulo NUM_REQ.
// Revision    : 1.0 - initial release
// ============================================================================
module rvsteel_rr_picker #(
    parameter int NUM_REQ   = 2,
    parameter int IDX_WIDTH = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0]   i_request,
    input  logic [IDX_WIDTH-1:0] i_ptr,
    output logic [NUM_REQ-1:0]   o_winner,
    output logic [IDX_WIDTH-1:0] o_winner_idx,
    output logic                 o_valid
);

    logic [IDX_WIDTH-1:0] w_idx;

    // Scan from the pointer upward; the first hit wins
    always_comb begin
        o_winner     = '0;
        o_winner_idx = '0;
        o_valid      = 1'b0;
        w_idx        = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = IDX_WIDTH'((int'(i_ptr) + k) % NUM_REQ);
            if (!o_valid && i_request[w_idx]) begin
                o_valid         = 1'b1;
                o_winner[w_idx] = 1'b1;
                o_winner_idx    = w_idx;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/rvsteel_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rvsteel_bus_arbiter
// Description : Round-robin arbiter sharing one bus manager port between
//               NUM_MANAGERS requesters, one transaction at a time, with an
//               optional timeout that force-completes unanswered accesses.
// Revision    : 1.0 - initial release
// ============================================================================
module rvsteel_bus_arbiter
    import rvsteel_bus_arbiter_defines::*;
#(
    parameter int NUM_MANAGERS   = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic [NUM_MANAGERS*c_ADDR_WIDTH-1:0] mgr_rw_address,
    input  logic [NUM_MANAGERS-1:0]              mgr_read_request,
    output logic [NUM_MANAGERS*c_DATA_WIDTH-1:0] mgr_read_data,
    output logic [NUM_MANAGERS-1:0]              mgr_read_response,
    input  logic [NUM_MANAGERS*c_DATA_WIDTH-1:0] mgr_write_data,
    input  logic [NUM_MANAGERS*c_STRB_WIDTH-1:0] mgr_write_strobe,
    input  logic [NUM_MANAGERS-1:0]              mgr_write_request,
    output logic [NUM_MANAGERS-1:0]              mgr_write_response,
    output logic [c_ADDR_WIDTH-1:0]              bus_rw_address,
    input  logic [c_DATA_WIDTH-1:0]              bus_read_data,
    output logic                                 bus_read_request,
    input  logic                                 bus_read_response,
    output logic [c_DATA_WIDTH-1:0]              bus_write_data,
    output logic [c_STRB_WIDTH-1:0]              bus_write_strobe,
    output logic                                 bus_write_request,
    input  logic                                 bus_write_response,
    output logic [NUM_MANAGERS-1:0]              grant,
    output logic                                 bus_timeout
);

    localparam int c_IDX_W = $clog2(NUM_MANAGERS);
    localparam int c_CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(TIMEOUT_CYCLES);

    state_t                  r_state, w_state_next;
    logic [NUM_MANAGERS-1:0] r_grant, w_grant_next;
    logic [c_IDX_W-1:0]      r_grant_idx, w_idx_next;
    logic [c_IDX_W-1:0]      r_ptr, w_ptr_next;
    logic                    r_type, w_type_next;
    logic [c_CNT_W-1:0]      r_count, w_count_next;

    logic [NUM_MANAGERS-1:0] w_pick_onehot;
    logic [c_IDX_W-1:0]      w_pick_idx;
    logic                    w_pick_valid;
    logic                    w_resp_match;
    logic                    w_timeout_hit;
    logic                    w_done;
    logic                    w_timeout;
    logic [c_ADDR_WIDTH-1:0] w_addr;
    logic [c_DATA_WIDTH-1:0] w_wdata;
    logic [c_STRB_WIDTH-1:0] w_wstrb;

    rvsteel_rr_picker #(
        .NUM_REQ   (NUM_MANAGERS),
        .IDX_WIDTH (c_IDX_W)
    ) u_picker (
        .i_request    (mgr_read_request | mgr_write_request),
        .i_ptr        (r_ptr),
        .o_winner     (w_pick_onehot),
        .o_winner_idx (w_pick_idx),
        .o_valid      (w_pick_valid)
    );

    // State register; reset abandons any in-flight transaction silently
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_grant     <= '0;
            r_grant_idx <= '0;
            r_ptr       <= '0;
            r_type      <= c_TYPE_READ;
            r_count     <= '0;
        end else begin
            r_state     <= w_state_next;
            r_grant     <= w_grant_next;
            r_grant_idx <= w_idx_next;
            r_ptr       <= w_ptr_next;
            r_type      <= w_type_next;
            r_count     <= w_count_next;
        end
    end

    // Next-state logic: arbitrate in IDLE, complete on response or timeout
    always_comb begin
        w_state_next = r_state;
        w_grant_next = r_grant;
        w_idx_next   = r_grant_idx;
        w_ptr_next   = r_ptr;
        w_type_next  = r_type;
        w_count_next = r_count;
        w_done       = 1'b0;
        w_timeout    = 1'b0;

        // Only a response of the recorded type counts
        w_resp_match  = (r_type == c_TYPE_WRITE) ? bus_write_response : bus_read_response;
        w_timeout_hit = (TIMEOUT_CYCLES != 0) && (r_count == c_CNT_MAX);

        case (r_state)
            S_IDLE: begin
                if (w_pick_valid) begin
                    w_state_next = S_ISSUE;
                    w_grant_next = w_pick_onehot;
                    w_idx_next   = w_pick_idx;
                    // Write takes precedence when a manager raises both
                    w_type_next  = (|(mgr_write_request & w_pick_onehot)) ? c_TYPE_WRITE
                                                                         : c_TYPE_READ;
                end
            end
            S_ISSUE: begin
                if (w_resp_match) begin
                    w_done = 1'b1;
                end else begin
                    w_state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (w_resp_match) begin
                    w_done = 1'b1;
                end else if (w_timeout_hit) begin
                    w_done    = 1'b1;
                    w_timeout = 1'b1;
                end else if (r_count != c_CNT_MAX) begin
                    w_count_next = r_count + c_CNT_W'(1);
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase

        if (w_done) begin
            w_state_next = S_IDLE;
            w_grant_next = '0;
            w_count_next = '0;
            w_ptr_next   = (r_grant_idx == c_IDX_W'(NUM_MANAGERS - 1)) ? '0
                                                                       : r_grant_idx + c_IDX_W'(1);
        end
    end

    // Bus-side mux from the granted manager; one-hot grant gives 0 in IDLE
    always_comb begin
        w_addr  = '0;
        w_wdata = '0;
        w_wstrb = '0;
        for (int i = 0; i < NUM_MANAGERS; i++) begin
            if (r_grant[i]) begin
                w_addr  = w_addr  | mgr_rw_address[i*c_ADDR_WIDTH +: c_ADDR_WIDTH];
                w_wdata = w_wdata | mgr_write_data[i*c_DATA_WIDTH +: c_DATA_WIDTH];
                w_wstrb = w_wstrb | mgr_write_strobe[i*c_STRB_WIDTH +: c_STRB_WIDTH];
            end
        end
    end

    assign bus_rw_address     = w_addr;
    assign bus_write_data     = w_wdata;
    assign bus_write_strobe   = w_wstrb;
    assign bus_read_request   = (r_state == S_ISSUE) && (r_type == c_TYPE_READ);
    assign bus_write_request  = (r_state == S_ISSUE) && (r_type == c_TYPE_WRITE);
    assign grant              = r_grant;
    assign bus_timeout        = w_timeout;
    assign mgr_read_response  = r_grant & {NUM_MANAGERS{w_done && (r_type == c_TYPE_READ)}};
    assign mgr_write_response = r_grant & {NUM_MANAGERS{w_done && (r_type == c_TYPE_WRITE)}};

    // Read data is broadcast, except the timed-out manager sees zero
    generate
        for (genvar i = 0; i < NUM_MANAGERS; i++) begin : g_rdata
            assign mgr_read_data[i*c_DATA_WIDTH +: c_DATA_WIDTH] =
                (w_timeout && r_grant[i]) ? '0 : bus_read_data;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_rvsteel_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rvsteel_bus_arbiter
// Description : Self-checking bench for rvsteel_bus_arbiter: directed
//               scenarios plus randomized traffic against a transaction model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rvsteel_bus_arbiter;

    localparam int N  = 2;
    localparam int TO = 4;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [N*32-1:0]   mgr_rw_address;
    logic [N-1:0]      mgr_read_request;
    logic [N*32-1:0]   mgr_read_data;
    logic [N-1:0]      mgr_read_response;
    logic [N*32-1:0]   mgr_write_data;
    logic [N*4-1:0]    mgr_write_strobe;
    logic [N-1:0]      mgr_write_request;
    logic [N-1:0]      mgr_write_response;
    logic [31:0]       bus_rw_address;
    logic [31:0]       bus_read_data;
    logic              bus_read_request;
    logic              bus_read_response;
    logic [31:0]       bus_write_data;
    logic [3:0]        bus_write_strobe;
    logic              bus_write_request;
    logic              bus_write_response;
    logic [N-1:0]      grant;
    logic              bus_timeout;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clock = ~clock;

    rvsteel_bus_arbiter #(
        .NUM_MANAGERS   (N),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .mgr_rw_address     (mgr_rw_address),
        .mgr_read_request   (mgr_read_request),
        .mgr_read_data      (mgr_read_data),
        .mgr_read_response  (mgr_read_response),
        .mgr_write_data     (mgr_write_data),
        .mgr_write_strobe   (mgr_write_strobe),
        .mgr_write_request  (mgr_write_request),
        .mgr_write_response (mgr_write_response),
        .bus_rw_address     (bus_rw_address),
        .bus_read_data      (bus_read_data),
        .bus_read_request   (bus_read_request),
        .bus_read_response  (bus_read_response),
        .bus_write_data     (bus_write_data),
        .bus_write_strobe   (bus_write_strobe),
        .bus_write_request  (bus_write_request),
        .bus_write_response (bus_write_response),
        .grant              (grant),
        .bus_timeout        (bus_timeout)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        mgr_rw_address     = '0;
        mgr_read_request   = '0;
        mgr_write_data     = '0;
        mgr_write_strobe   = '0;
        mgr_write_request  = '0;
        bus_read_data      = '0;
        bus_read_response  = 1'b0;
        bus_write_response = 1'b0;
    endtask

    task automatic test_reset();
        mgr_read_request   = '1;
        mgr_write_request  = '1;
        mgr_rw_address     = '1;
        mgr_write_data     = '1;
        mgr_write_strobe   = '1;
        bus_read_response  = 1'b1;
        bus_write_response = 1'b1;
        tick();
        tick();
        #1;
        n_checks++; if (grant !== '0) $display("FAIL reset_grant: got %b want 0", grant); else n_pass++;
        n_checks++; if ({bus_read_request, bus_write_request} !== 2'b00)
            $display("FAIL reset_bus_req: got %b want 00", {bus_read_request, bus_write_request}); else n_pass++;
        n_checks++; if ({bus_rw_address, bus_write_data, bus_write_strobe} !== '0)
            $display("FAIL reset_bus_mux: got %h/%h/%h want 0", bus_rw_address, bus_write_data, bus_write_strobe); else n_pass++;
        n_checks++; if ({mgr_read_response, mgr_write_response, bus_timeout} !== '0)
            $display("FAIL reset_resp: got %b/%b/%b want 0", mgr_read_response, mgr_write_response, bus_timeout); else n_pass++;
        clear_inputs();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_round_robin();
        logic [31:0] addr_t [2];
        logic [31:0] data_t [2];
        logic [3:0]  strb_t [2];
        logic [N-1:0] exp_g;
        int w;
        addr_t = '{32'h0000_0100, 32'h0000_0200};
        data_t = '{32'hAAAA_0000, 32'h5555_1111};
        strb_t = '{4'h3, 4'hC};
        mgr_rw_address    = {addr_t[1], addr_t[0]};
        mgr_write_data    = {data_t[1], data_t[0]};
        mgr_write_strobe  = {strb_t[1], strb_t[0]};
        mgr_write_request = 2'b11;
        for (int k = 0; k < 4; k++) begin
            w = k % 2;
            exp_g = '0;
            exp_g[w] = 1'b1;
            #1;
            n_checks++; if (grant !== '0 || mgr_write_response !== '0)
                $display("FAIL rr_idle_%0d: grant %b resp %b want 0/0", k, grant, mgr_write_response); else n_pass++;
            tick();
            #1;
            n_checks++; if (grant !== exp_g || bus_write_request !== 1'b1)
                $display("FAIL rr_issue_%0d: grant %b wreq %b want %b/1", k, grant, bus_write_request, exp_g); else n_pass++;
            n_checks++; if (bus_rw_address !== addr_t[w] || bus_write_data !== data_t[w] || bus_write_strobe !== strb_t[w])
                $display("FAIL rr_mux_%0d: got %h/%h/%h want %h/%h/%h", k, bus_rw_address, bus_write_data,
                         bus_write_strobe, addr_t[w], data_t[w], strb_t[w]); else n_pass++;
            tick();
            bus_write_response = 1'b1;
            #1;
            n_checks++; if (mgr_write_response !== exp_g || bus_write_request !== 1'b0)
                $display("FAIL rr_resp_%0d: resp %b wreq %b want %b/0", k, mgr_write_response, bus_write_request, exp_g); else n_pass++;
            tick();
            bus_write_response = 1'b0;
            if (k == 3) mgr_write_request = '0;
        end
        tick();
        #1;
        n_checks++; if (grant !== '0) $display("FAIL rr_end_grant: got %b want 0", grant); else n_pass++;
    endtask

    task automatic test_basic_read();
        mgr_read_request     = 2'b01;
        mgr_rw_address[31:0] = 32'h0000_0010;
        #1;
        n_checks++; if (grant !== '0 || bus_read_request !== 1'b0)
            $display("FAIL basic_c0: grant %b rreq %b want 0/0", grant, bus_read_request); else n_pass++;
        tick();
        #1;
        n_checks++; if (grant !== 2'b01 || bus_read_request !== 1'b1 || bus_rw_address !== 32'h0000_0010)
            $display("FAIL basic_c1: grant %b rreq %b addr %h want 01/1/00000010", grant, bus_read_request, bus_rw_address); else n_pass++;
        n_checks++; if (mgr_read_response !== '0) $display("FAIL basic_c1_resp: got %b want 0", mgr_read_response); else n_pass++;
        tick();
        bus_read_response = 1'b1;
        bus_read_data     = 32'hDEAD_BEEF;
        #1;
        n_checks++; if (mgr_read_response !== 2'b01 || mgr_read_data[31:0] !== 32'hDEAD_BEEF)
            $display("FAIL basic_c2: resp %b data %h want 01/deadbeef", mgr_read_response, mgr_read_data[31:0]); else n_pass++;
        n_checks++; if (grant !== 2'b01 || bus_read_request !== 1'b0)
            $display("FAIL basic_c2_grant: grant %b rreq %b want 01/0", grant, bus_read_request); else n_pass++;
        tick();
        bus_read_response = 1'b0;
        mgr_read_request  = '0;
        #1;
        n_checks++; if (grant !== '0 || mgr_read_response !== '0)
            $display("FAIL basic_c3: grant %b resp %b want 0/0", grant, mgr_read_response); else n_pass++;
    endtask

    task automatic test_reset_mid();
        mgr_read_request     = 2'b01;
        mgr_rw_address[31:0] = 32'h3000_0000;
        tick();
        tick();
        #1;
        n_checks++; if (grant !== 2'b01 || bus_rw_address !== 32'h3000_0000)
            $display("FAIL rmid_wait: grant %b addr %h want 01/30000000", grant, bus_rw_address); else n_pass++;
        #2;
        reset = 1'b1;
        #1;
        n_checks++; if (grant !== '0 || bus_rw_address !== '0 || bus_read_request !== 1'b0 || bus_write_request !== 1'b0)
            $display("FAIL rmid_async: grant %b addr %h req %b%b want 0", grant, bus_rw_address,
                     bus_read_request, bus_write_request); else n_pass++;
        mgr_read_request = '0;
        tick();
        reset             = 1'b0;
        bus_read_response = 1'b1;
        bus_read_data     = 32'h1111_2222;
        #1;
        n_checks++; if (mgr_read_response !== '0 || grant !== '0)
            $display("FAIL rmid_stale: resp %b grant %b want 0/0", mgr_read_response, grant); else n_pass++;
        tick();
        bus_read_response     = 1'b0;
        mgr_read_request      = 2'b11;
        mgr_rw_address[63:32] = 32'h0000_0040;
        tick();
        #1;
        n_checks++; if (grant !== 2'b01) $display("FAIL rmid_ptr: grant %b want 01", grant); else n_pass++;
        tick();
        bus_read_response = 1'b1;
        #1;
        n_checks++; if (mgr_read_response !== 2'b01) $display("FAIL rmid_resp: got %b want 01", mgr_read_response); else n_pass++;
        tick();
        bus_read_response = 1'b0;
        mgr_read_request  = '0;
    endtask

    task automatic test_timeout();
        mgr_read_request     = 2'b01;
        mgr_rw_address[31:0] = 32'h9000_0000;
        bus_read_data        = 32'hCAFE_F00D;
        tick();
        #1;
        n_checks++; if (bus_read_request !== 1'b1 || bus_rw_address !== 32'h9000_0000)
            $display("FAIL to_issue: rreq %b addr %h want 1/90000000", bus_read_request, bus_rw_address); else n_pass++;
        for (int w = 0; w < TO; w++) begin
            tick();
            #1;
            n_checks++; if (mgr_read_response !== '0 || bus_timeout !== 1'b0 || grant !== 2'b01)
                $display("FAIL to_wait_%0d: resp %b to %b grant %b want 0/0/01", w, mgr_read_response,
                         bus_timeout, grant); else n_pass++;
        end
        tick();
        #1;
        n_checks++; if (mgr_read_response !== 2'b01 || bus_timeout !== 1'b1)
            $display("FAIL to_fire: resp %b to %b want 01/1", mgr_read_response, bus_timeout); else n_pass++;
        n_checks++; if (mgr_read_data[31:0] !== 32'h0 || mgr_read_data[63:32] !== 32'hCAFE_F00D)
            $display("FAIL to_data: got %h/%h want 0/cafef00d", mgr_read_data[31:0], mgr_read_data[63:32]); else n_pass++;
        tick();
        mgr_read_request      = 2'b10;
        mgr_rw_address[63:32] = 32'h0000_0020;
        #1;
        n_checks++; if (bus_timeout !== 1'b0 || grant !== '0)
            $display("FAIL to_after: to %b grant %b want 0/0", bus_timeout, grant); else n_pass++;
        tick();
        #1;
        n_checks++; if (grant !== 2'b10 || bus_rw_address !== 32'h0000_0020)
            $display("FAIL to_next_issue: grant %b addr %h want 10/00000020", grant, bus_rw_address); else n_pass++;
        tick();
        bus_read_response = 1'b1;
        bus_read_data     = 32'h1234_5678;
        #1;
        n_checks++; if (mgr_read_response !== 2'b10 || mgr_read_data[63:32] !== 32'h1234_5678 || bus_timeout !== 1'b0)
            $display("FAIL to_next_resp: resp %b data %h to %b want 10/12345678/0", mgr_read_response,
                     mgr_read_data[63:32], bus_timeout); else n_pass++;
        tick();
        bus_read_response = 1'b0;
        mgr_read_request  = '0;
    endtask

    task automatic test_read_write();
        mgr_read_request        = 2'b10;
        mgr_write_request       = 2'b10;
        mgr_rw_address[63:32]   = 32'h0000_0050;
        mgr_write_data[63:32]   = 32'hA5A5_5A5A;
        mgr_write_strobe[7:4]   = 4'b0110;
        tick();
        #1;
        n_checks++; if (bus_write_request !== 1'b1 || bus_read_request !== 1'b0 || grant !== 2'b10)
            $display("FAIL rw_issue: wreq %b rreq %b grant %b want 1/0/10", bus_write_request,
                     bus_read_request, grant); else n_pass++;
        n_checks++; if (bus_write_data !== 32'hA5A5_5A5A || bus_write_strobe !== 4'b0110)
            $display("FAIL rw_mux: data %h strb %b want a5a55a5a/0110", bus_write_data, bus_write_strobe); else n_pass++;
        tick();
        bus_write_response = 1'b1;
        bus_read_response  = 1'b1;
        #1;
        n_checks++; if (mgr_write_response !== 2'b10 || mgr_read_response !== '0)
            $display("FAIL rw_resp: wresp %b rresp %b want 10/00", mgr_write_response, mgr_read_response); else n_pass++;
        tick();
        clear_inputs();
    endtask

    task automatic test_random();
        logic [N-1:0] seen, exp_g, exp_r, exp_w;
        int  m_ptr, m_win, dev_lat;
        bit  m_busy, m_wr, issue_now, issue_next, dev_pend, done, found;
        seen = '0; m_ptr = 0; m_win = 0; dev_lat = 0;
        m_busy = 0; m_wr = 0; issue_next = 0; dev_pend = 0;
        clear_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            tick();
            // Managers: idle or just-answered ones may start a new transaction
            for (int i = 0; i < N; i++) begin
                if (seen[i] || !(mgr_read_request[i] | mgr_write_request[i])) begin
                    int r;
                    r = $urandom_range(0, 4);
                    mgr_read_request[i]         = (r == 0 || r == 2);
                    mgr_write_request[i]        = (r == 1 || r == 2);
                    mgr_rw_address[32*i +: 32]  = $urandom;
                    mgr_write_data[32*i +: 32]  = $urandom;
                    mgr_write_strobe[4*i +: 4]  = 4'($urandom);
                    seen[i] = 1'b0;
                end
            end
            issue_now = issue_next;
            exp_g = '0;
            if (m_busy) exp_g[m_win] = 1'b1;
            n_checks++; if (grant !== exp_g) $display("FAIL rnd_grant@%0d: got %b want %b", cyc, grant, exp_g); else n_pass++;
            n_checks++; if (bus_read_request !== (issue_now && !m_wr) || bus_write_request !== (issue_now && m_wr))
                $display("FAIL rnd_busreq@%0d: got %b%b want %b%b", cyc, bus_read_request, bus_write_request,
                         issue_now && !m_wr, issue_now && m_wr); else n_pass++;
            if (issue_now) begin
                n_checks++; if (bus_rw_address !== mgr_rw_address[32*m_win +: 32])
                    $display("FAIL rnd_addr@%0d: got %h want %h", cyc, bus_rw_address, mgr_rw_address[32*m_win +: 32]); else n_pass++;
                if (m_wr) begin
                    n_checks++; if (bus_write_data !== mgr_write_data[32*m_win +: 32] || bus_write_strobe !== mgr_write_strobe[4*m_win +: 4])
                        $display("FAIL rnd_wdata@%0d: got %h/%h want %h/%h", cyc, bus_write_data, bus_write_strobe,
                                 mgr_write_data[32*m_win +: 32], mgr_write_strobe[4*m_win +: 4]); else n_pass++;
                end
                dev_pend = 1;
                dev_lat  = $urandom_range(0, 3);
            end else if (!m_busy) begin
                n_checks++; if (bus_rw_address !== '0) $display("FAIL rnd_idle_addr@%0d: got %h want 0", cyc, bus_rw_address); else n_pass++;
            end
            // Device: noise on the wrong type only; the right type on completion
            done = 0;
            bus_read_data      = $urandom;
            bus_read_response  = ($urandom_range(0, 3) == 0);
            bus_write_response = ($urandom_range(0, 3) == 0);
            if (m_busy) begin
                if (m_wr) bus_write_response = 1'b0;
                else      bus_read_response  = 1'b0;
            end
            if (dev_pend) begin
                if (dev_lat == 0) begin
                    done     = 1;
                    dev_pend = 0;
                    if (m_wr) bus_write_response = 1'b1;
                    else      bus_read_response  = 1'b1;
                end else begin
                    dev_lat--;
                end
            end
            #1;
            exp_r = (done && !m_wr) ? exp_g : '0;
            exp_w = (done &&  m_wr) ? exp_g : '0;
            n_checks++; if (mgr_read_response !== exp_r || mgr_write_response !== exp_w)
                $display("FAIL rnd_resp@%0d: got %b/%b want %b/%b", cyc, mgr_read_response, mgr_write_response,
                         exp_r, exp_w); else n_pass++;
            if (done && !m_wr) begin
                n_checks++; if (mgr_read_data[32*m_win +: 32] !== bus_read_data)
                    $display("FAIL rnd_rdata@%0d: got %h want %h", cyc, mgr_read_data[32*m_win +: 32], bus_read_data); else n_pass++;
            end
            n_checks++; if (bus_timeout !== 1'b0) $display("FAIL rnd_timeout@%0d: got %b want 0", cyc, bus_timeout); else n_pass++;
            // Model: completion frees the bus; an idle bus picks the next requester round-robin
            issue_next = 0;
            if (done) begin
                seen[m_win] = 1'b1;
                m_busy = 0;
                m_ptr  = (m_win + 1) % N;
            end else if (!m_busy) begin
                found = 0;
                for (int k = 0; k < N; k++) begin
                    int j;
                    j = (m_ptr + k) % N;
                    if (!found && (mgr_read_request[j] || mgr_write_request[j])) begin
                        found = 1;
                        m_win = j;
                        m_wr  = mgr_write_request[j];
                    end
                end
                if (found) begin
                    m_busy     = 1;
                    issue_next = 1;
                end
            end
        end
        clear_inputs();
        tick();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_round_robin();
        test_basic_read();
        test_reset_mid();
        test_timeout();
        test_read_write();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit, passed %0d of %0d", n_pass, n_checks);
        $fatal(1);
    end

endmodule
`default_nettype wire
